// File: rtl/branch_resolve_arbiter.sv
// Purpose : buffers branch completions and issues one resolution per cycle to the
//           branch stack, oldest mispredict first, otherwise lowest occupied slot.
// Latency : a completion captured at edge t can issue at edge t+1 (out_* registered).
// Backpr. : in_ready drops when fewer than N_IN slots are free; the output side has
//           no backpressure, and the branch stack takes every resolution.
// Ports   : clock/reset (async, active-low); in_* = N_IN completion lanes;
//           out_* = one registered resolution per cycle; occupancy = valid entries.
module branch_resolve_arbiter #(
  parameter int BMW    = 8,
  parameter int N_IN   = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_IN-1:0]            in_valid,
  input  logic [N_IN*BMW-1:0]        in_bmm,
  input  logic [N_IN*BMW-1:0]        in_bmask,
  input  logic [N_IN-1:0]            in_mispred,
  input  logic [N_IN*ADDR_W-1:0]     in_target,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [BMW-1:0]             out_bmm,
  output logic                       out_mispred,
  output logic [ADDR_W-1:0]          out_target,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              v;
    logic [BMW-1:0]    bmm;
    logic [BMW-1:0]    bmask;
    logic              mis;
    logic [ADDR_W-1:0] tgt;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic              out_valid_q, out_valid_d;
  logic [BMW-1:0]    out_bmm_q, out_bmm_d;
  logic              out_mis_q, out_mis_d;
  logic [ADDR_W-1:0] out_tgt_q, out_tgt_d;

  logic [DEPTH-1:0]  mis_ok;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic [BMW-1:0]    sel_bmm;
  logic              sel_mis;
  logic [ADDR_W-1:0] sel_tgt;
  logic              mis_issue, cor_issue;

  // Ready depends on registered occupancy only; held low while in reset so
  // every output reads 0 during reset.
  assign in_ready    = reset & (occ_q <= OCC_W'(DEPTH - N_IN));
  assign out_valid   = out_valid_q;
  assign out_bmm     = out_bmm_q;
  assign out_mispred = out_mis_q;
  assign out_target  = out_tgt_q;
  assign occupancy   = occ_q;

  // A mispredict is issuable only if no other pending mispredict is older,
  // i.e. none of the other mispredicts' tags appear in its dependency mask.
  always_comb begin
    mis_ok = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mis_ok[i] = ent_q[i].v && ent_q[i].mis;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ent_q[j].v && ent_q[j].mis &&
            ((ent_q[i].bmask & ent_q[j].bmm) != '0)) begin
          mis_ok[i] = 1'b0;
        end
      end
    end
  end

  // Lowest valid slot by default; lowest issuable mispredict overrides it.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ent_q[i].v) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (mis_ok[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
    sel_bmm   = ent_q[sel_idx].bmm;
    sel_mis   = ent_q[sel_idx].mis;
    sel_tgt   = ent_q[sel_idx].tgt;
    mis_issue = sel_vld && sel_mis;
    cor_issue = sel_vld && !sel_mis;
  end

  always_comb begin
    out_valid_d = sel_vld;
    out_bmm_d   = sel_vld ? sel_bmm : '0;
    out_mis_d   = sel_vld ? sel_mis : 1'b0;
    out_tgt_d   = sel_vld ? sel_tgt : '0;
  end

  // Next buffer state: retire the selected entry, apply its resolution to the
  // survivors and to the incoming lanes, then drop lanes into free slots.
  always_comb begin
    entry_t ln;
    logic   placed;
    ln     = '0;
    placed = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    if (sel_vld) begin
      ent_d[sel_idx].v = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_d[i].v) begin
        if (mis_issue && ((ent_d[i].bmask & sel_bmm) != '0)) begin
          ent_d[i].v = 1'b0;
        end else if (cor_issue) begin
          ent_d[i].bmask = ent_d[i].bmask & ~sel_bmm;
        end
      end
    end
    // Slots freed by this edge's retire/squash are reusable immediately, so
    // fill order is simply lowest free slot, lane 0 first.
    for (int l = 0; l < N_IN; l++) begin
      ln.v     = in_valid[l] & in_ready;
      ln.bmm   = in_bmm[l*BMW +: BMW];
      ln.bmask = in_bmask[l*BMW +: BMW];
      ln.mis   = in_mispred[l];
      ln.tgt   = in_target[l*ADDR_W +: ADDR_W];
      if (mis_issue && ((ln.bmask & sel_bmm) != '0)) begin
        ln.v = 1'b0;
      end
      if (cor_issue) begin
        ln.bmask = ln.bmask & ~sel_bmm;
      end
      placed = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ln.v && !placed && !ent_d[i].v) begin
          ent_d[i] = ln;
          placed   = 1'b1;
        end
      end
    end
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_d[i].v) begin
        occ_d = occ_d + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_bmm_q   <= '0;
      out_mis_q   <= 1'b0;
      out_tgt_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_bmm_q   <= out_bmm_d;
      out_mis_q   <= out_mis_d;
      out_tgt_q   <= out_tgt_d;
    end
  end

  // Input legality: tags unique across buffer and accepted lanes, one-hot,
  // and a branch never depends on itself.
  logic dup_bad, onehot_bad, self_bad;
  always_comb begin
    logic [BMW-1:0] seen;
    logic [BMW-1:0] lb;
    seen       = '0;
    lb         = '0;
    dup_bad    = 1'b0;
    onehot_bad = 1'b0;
    self_bad   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].v) begin
        if ((seen & ent_q[i].bmm) != '0) dup_bad = 1'b1;
        seen = seen | ent_q[i].bmm;
      end
    end
    for (int l = 0; l < N_IN; l++) begin
      if (in_valid[l] && in_ready) begin
        lb = in_bmm[l*BMW +: BMW];
        if ((seen & lb) != '0) dup_bad = 1'b1;
        if (!$onehot(lb)) onehot_bad = 1'b1;
        if ((lb & in_bmask[l*BMW +: BMW]) != '0) self_bad = 1'b1;
        seen = seen | lb;
      end
    end
  end

  a_unique_tag : assert property (@(posedge clock) disable iff (!reset) !dup_bad);
  a_onehot_tag : assert property (@(posedge clock) disable iff (!reset) !onehot_bad);
  a_no_self_dep: assert property (@(posedge clock) disable iff (!reset) !self_bad);

endmodule

// File: tb/tb_branch_resolve_arbiter.sv
module tb_branch_resolve_arbiter;
  localparam int BMW = 8, N_IN = 2, DEPTH = 4, ADDR_W = 32;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [N_IN-1:0]        in_valid = '0;
  logic [N_IN*BMW-1:0]    in_bmm = '0;
  logic [N_IN*BMW-1:0]    in_bmask = '0;
  logic [N_IN-1:0]        in_mispred = '0;
  logic [N_IN*ADDR_W-1:0] in_target = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic [BMW-1:0]         out_bmm;
  logic                   out_mispred;
  logic [ADDR_W-1:0]      out_target;
  logic [2:0]             occupancy;

  always #5 clock = ~clock;

  branch_resolve_arbiter #(.BMW(BMW), .N_IN(N_IN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_bmm(in_bmm), .in_bmask(in_bmask),
    .in_mispred(in_mispred), .in_target(in_target), .in_ready(in_ready),
    .out_valid(out_valid), .out_bmm(out_bmm), .out_mispred(out_mispred),
    .out_target(out_target), .occupancy(occupancy)
  );

  typedef struct { bit v; bit [7:0] bmm; bit [7:0] bmask; bit mis; bit [31:0] tgt; } ent_t;
  typedef struct { bit [7:0] bmm; bit mis; bit [31:0] tgt; } res_t;

  ent_t mdl [DEPTH];
  res_t expq [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int mdl_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mdl[i].v) n++;
    return n;
  endfunction

  function automatic bit mdl_ready();
    return (DEPTH - mdl_count()) >= N_IN;
  endfunction

  function automatic bit [7:0] mdl_live();
    bit [7:0] m = '0;
    for (int i = 0; i < DEPTH; i++) if (mdl[i].v) m |= mdl[i].bmm;
    return m;
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i].v = 1'b0;
    expq.delete();
  endfunction

  // One clock edge of the reference: pick, retire, resolve, then accept lanes.
  function automatic void mdl_step(input ent_t l0, input ent_t l1);
    int   s = -1;
    ent_t sel;
    ent_t lanes [2];
    lanes[0] = l0;
    lanes[1] = l1;
    sel = '{default: 0};
    // oldest mispredict: one that no other pending mispredict is older than
    for (int i = 0; i < DEPTH; i++) begin
      bit has_older = 1'b0;
      if (s < 0 && mdl[i].v && mdl[i].mis) begin
        for (int j = 0; j < DEPTH; j++)
          if (j != i && mdl[j].v && mdl[j].mis && ((mdl[j].bmm & mdl[i].bmask) != 0))
            has_older = 1'b1;
        if (!has_older) s = i;
      end
    end
    if (s < 0)
      for (int i = 0; i < DEPTH; i++) if (s < 0 && mdl[i].v) s = i;
    if (s >= 0) begin
      sel = mdl[s];
      expq.push_back('{bmm: sel.bmm, mis: sel.mis, tgt: sel.tgt});
      mdl[s].v = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (mdl[i].v) begin
          if (sel.mis && ((mdl[i].bmask & sel.bmm) != 0)) mdl[i].v = 1'b0;
          else if (!sel.mis) mdl[i].bmask &= ~sel.bmm;
        end
      end
    end
    for (int l = 0; l < 2; l++) begin
      bit placed = 1'b0;
      if (lanes[l].v && !(s >= 0 && sel.mis && ((lanes[l].bmask & sel.bmm) != 0))) begin
        if (s >= 0 && !sel.mis) lanes[l].bmask &= ~sel.bmm;
        for (int i = 0; i < DEPTH; i++) begin
          if (!placed && !mdl[i].v) begin
            mdl[i] = lanes[l];
            placed = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic ent_t mk(input bit v, input bit [7:0] bmm, input bit [7:0] bmask, input bit mis);
    ent_t e;
    e.v = v; e.bmm = bmm; e.bmask = bmask; e.mis = mis;
    e.tgt = v ? $urandom : 32'h0;
    return e;
  endfunction

  ent_t idle;

  task automatic step(input ent_t l0, input ent_t l1);
    @(negedge clock);
    check("occupancy", occupancy, mdl_count());
    check("in_ready", in_ready, mdl_ready());
    if (l0.v || l1.v) check("lane_vs_ready", in_ready, 1);
    in_valid   = {l1.v, l0.v};
    in_bmm     = {l1.bmm, l0.bmm};
    in_bmask   = {l1.bmask, l0.bmask};
    in_mispred = {l1.mis, l0.mis};
    in_target  = {l1.tgt, l0.tgt};
    mdl_step(l0, l1);
  endtask

  task automatic expect_out(input string name, input bit vld, input bit [7:0] bmm, input bit mis);
    @(posedge clock);
    #1;
    check({name, "_valid"}, out_valid, vld);
    if (vld) begin
      check({name, "_bmm"}, out_bmm, bmm);
      check({name, "_mispred"}, out_mispred, mis);
    end
  endtask

  // Scoreboard monitor: every cycle out of reset, the DUT output must match
  // the head of the expected queue (or be idle and zero if nothing is due).
  always @(posedge clock) begin : monitor
    res_t r;
    bit   due;
    #1;
    if (reset) begin
      due = (expq.size() != 0);
      check("out_valid", out_valid, due);
      if (due) begin
        r = expq.pop_front();
        if (out_valid)
          check("out_resolution", {out_mispred, out_bmm, out_target}, {r.mis, r.bmm, r.tgt});
      end else begin
        check("out_idle_zero", {out_mispred, out_bmm, out_target}, 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : main
    bit [7:0] pend_b [$];
    idle = mk(0, 0, 0, 0);
    mdl_reset();

    // reset state: everything low while reset is held
    repeat (3) @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b1;

    // single correct resolution
    step(mk(1, 8'h01, 8'h00, 0), idle);
    step(idle, idle);
    expect_out("single", 1, 8'h01, 0);
    step(idle, idle);
    expect_out("single_after", 0, 8'h00, 0);

    // mispredict beats a lower-slot correct resolution
    step(mk(1, 8'h02, 8'h00, 0), mk(1, 8'h04, 8'h00, 1));
    step(idle, idle);
    expect_out("mis_prio_first", 1, 8'h04, 1);
    step(idle, idle);
    expect_out("mis_prio_second", 1, 8'h02, 0);

    // oldest mispredict wins, its dependent is squashed
    step(mk(1, 8'h08, 8'h01, 1), mk(1, 8'h01, 8'h00, 1));
    step(idle, idle);
    expect_out("oldest_mis", 1, 8'h01, 1);
    check("oldest_mis_occ", occupancy, 0);
    step(idle, idle);
    expect_out("oldest_mis_squashed", 0, 8'h00, 0);

    // mask cleanup after a correct resolution, dependent still issues
    step(mk(1, 8'h01, 8'h00, 0), mk(1, 8'h02, 8'h01, 0));
    step(idle, idle);
    expect_out("cleanup_first", 1, 8'h01, 0);
    step(idle, idle);
    expect_out("cleanup_second", 1, 8'h02, 0);

    // full / backpressure
    step(mk(1, 8'h10, 8'h00, 0), mk(1, 8'h20, 8'h00, 0));
    step(mk(1, 8'h40, 8'h00, 0), mk(1, 8'h80, 8'h00, 0));
    step(idle, idle);
    check("full_occ", occupancy, 3);
    check("full_ready", in_ready, 0);
    step(idle, idle);
    check("full_release_occ", occupancy, 2);
    check("full_release_ready", in_ready, 1);
    pend_b = '{8'h01, 8'h02, 8'h04, 8'h08};
    while (pend_b.size() != 0) begin
      if (mdl_ready()) begin
        bit [7:0] a, b;
        a = pend_b.pop_front();
        b = pend_b.pop_front();
        step(mk(1, a, 8'h00, 0), mk(1, b, 8'h00, 0));
      end else begin
        step(idle, idle);
      end
    end
    repeat (6) step(idle, idle);

    // asynchronous reset with three entries buffered
    step(mk(1, 8'h01, 8'h00, 0), mk(1, 8'h02, 8'h00, 0));
    step(mk(1, 8'h04, 8'h00, 0), mk(1, 8'h08, 8'h00, 0));
    step(idle, idle);
    check("pre_reset_occ", occupancy, 3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_occ", occupancy, 0);
    mdl_reset();
    in_valid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("post_reset_ready", in_ready, 1);
    step(idle, idle);

    // randomized traffic against the reference
    for (int c = 0; c < 1500; c++) begin
      ent_t ln [2];
      bit [7:0] live, used;
      ln[0] = idle;
      ln[1] = idle;
      if (mdl_ready()) begin
        live = mdl_live();
        used = live;
        for (int l = 0; l < 2; l++) begin
          if ($urandom_range(0, 3) != 0 && used != 8'hFF) begin
            bit [7:0] t;
            t = 8'h00;
            while ((t & ~used) == 0) t = 8'h01 << $urandom_range(0, 7);
            ln[l] = mk(1, t, used & ~t & 8'($urandom), $urandom_range(0, 3) == 0);
            ln[l].bmask &= (live | ((l == 1 && ln[0].v) ? ln[0].bmm : 8'h00));
            used |= t;
          end
        end
      end
      step(ln[0], ln[1]);
    end
    repeat (8) step(idle, idle);
    @(negedge clock);
    check("drain_queue_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
